// File: rtl/fpaddsub_pkg.sv
// Shared types and constants for the FP add/sub issue arbiter.
// The tag id is sized for the largest supported requester count (8).
package fpaddsub_pkg;

    localparam int          FP_W     = 32;
    localparam logic [31:0] FP_QNAN  = 32'h7FC00000;
    localparam logic        OP_ADD   = 1'b0;
    localparam logic        OP_SUB   = 1'b1;
    localparam int          TAG_ID_W = 3;

    typedef struct packed {
        logic                v;
        logic [TAG_ID_W-1:0] id;
    } tag_t;

endpackage

// File: rtl/fpaddsub_rr_pick.sv
// Combinational round-robin picker: first eligible index at or after ptr,
// wrapping modulo NREQ.
module fpaddsub_rr_pick
    import fpaddsub_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int ID_W = 2
) (
    input  logic [NREQ-1:0] elig,
    input  logic [ID_W-1:0] ptr,
    output logic [NREQ-1:0] grant,
    output logic [ID_W-1:0] winner,
    output logic            any
);

    logic [ID_W-1:0] cand;

    always_comb begin
        grant  = '0;
        winner = '0;
        any    = 1'b0;
        cand   = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = ID_W'((32'(ptr) + 32'(k)) % 32'(NREQ));
            if (!any && elig[cand]) begin
                any    = 1'b1;
                winner = cand;
            end
        end
        if (any) grant[winner] = 1'b1;
    end

endmodule

// File: rtl/fpaddsub_issue_arbiter.sv
// Shares one fixed-latency FP add/sub pipeline between NREQ requesters with
// round-robin issue, a tag shift register and one result slot per requester.
module fpaddsub_issue_arbiter
    import fpaddsub_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int PIPE_LAT = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [NREQ*32-1:0] req_a,
    input  logic [NREQ*32-1:0] req_b,
    input  logic [NREQ-1:0]    req_op,
    output logic               dp_valid,
    output logic [31:0]        dp_a,
    output logic [31:0]        dp_b,
    output logic               dp_op,
    input  logic               dp_res_valid,
    input  logic [31:0]        dp_res,
    output logic [NREQ-1:0]    res_valid,
    output logic [NREQ*32-1:0] res_data,
    input  logic [NREQ-1:0]    res_ready,
    output logic               err
);

    localparam int ID_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0] busy_q;
    logic [NREQ-1:0] elig;
    logic [NREQ-1:0] grant;
    logic [ID_W-1:0] ptr;
    logic [ID_W-1:0] winner;
    logic            any;
    logic [FP_W-1:0] sel_a;
    logic [FP_W-1:0] sel_b;
    logic            sel_op;
    logic [FP_W-1:0] ret_val;
    logic [NREQ-1:0] ret_hit;
    tag_t            tags [PIPE_LAT];
    tag_t            last;

    // Grants are masked during reset so every output reads zero while rst is high.
    assign elig      = req_valid & ~busy_q & {NREQ{~rst}};
    assign req_ready = grant;

    fpaddsub_rr_pick #(
        .NREQ (NREQ),
        .ID_W (ID_W)
    ) u_pick (
        .elig   (elig),
        .ptr    (ptr),
        .grant  (grant),
        .winner (winner),
        .any    (any)
    );

    assign sel_a   = req_a[FP_W*winner +: FP_W];
    assign sel_b   = req_b[FP_W*winner +: FP_W];
    assign sel_op  = req_op[winner];
    assign last    = tags[PIPE_LAT-1];
    assign ret_val = dp_res_valid ? dp_res : FP_QNAN;

    // Decoding the full tag id keeps the retire path free of variable part-selects.
    always_comb begin
        ret_hit = '0;
        for (int i = 0; i < NREQ; i++) begin
            ret_hit[i] = last.v && (last.id == TAG_ID_W'(i));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dp_valid  <= 1'b0;
            dp_a      <= '0;
            dp_b      <= '0;
            dp_op     <= 1'b0;
            ptr       <= '0;
            busy_q    <= '0;
            res_valid <= '0;
            res_data  <= '0;
            err       <= 1'b0;
            for (int i = 0; i < PIPE_LAT; i++) tags[i] <= '0;
        end else begin
            dp_valid <= any;
            if (any) begin
                dp_a  <= sel_a;
                dp_b  <= sel_b;
                dp_op <= sel_op;
                ptr   <= (winner == ID_W'(NREQ-1)) ? '0 : winner + 1'b1;
            end

            // Stage 0 always mirrors what is currently on dp_*.
            tags[0] <= '{v: any, id: TAG_ID_W'(winner)};
            for (int i = 1; i < PIPE_LAT; i++) tags[i] <= tags[i-1];

            for (int i = 0; i < NREQ; i++) begin
                if (grant[i]) begin
                    busy_q[i] <= 1'b1;
                end else if (res_valid[i] && res_ready[i]) begin
                    busy_q[i]    <= 1'b0;
                    res_valid[i] <= 1'b0;
                end
                if (ret_hit[i]) begin
                    res_valid[i]              <= 1'b1;
                    res_data[FP_W*i +: FP_W]  <= ret_val;
                end
            end

            if (last.v != dp_res_valid) err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fpaddsub_issue_arbiter.sv
// Directed bench for fpaddsub_issue_arbiter with a behavioural datapath that
// returns hand-computed sums PIPE_LAT-1 cycles after sampling dp_valid.
module tb_fpaddsub_issue_arbiter;

    localparam int NREQ     = 4;
    localparam int PIPE_LAT = 4;
    localparam logic [31:0] A_OPS [4] = '{32'h3F800000, 32'h40400000, 32'h40800000, 32'h41000000};
    localparam logic [31:0] B_OPS [4] = '{32'h40000000, 32'h3F800000, 32'h40800000, 32'h40000000};
    localparam logic [31:0] EXP   [4] = '{32'h40400000, 32'h40000000, 32'h41000000, 32'h40C00000};

    logic               clk = 1'b0;
    logic               rst;
    logic [NREQ-1:0]    req_valid, req_ready, req_op, res_valid, res_ready;
    logic [NREQ*32-1:0] req_a, req_b, res_data;
    logic               dp_valid, dp_op, dp_res_valid, err;
    logic [31:0]        dp_a, dp_b, dp_res;
    logic               drop_req2, spur;
    int                 checks   = 0;
    int                 failures = 0;

    logic               mv    [PIPE_LAT-1];
    logic               mdrop [PIPE_LAT-1];
    logic [31:0]        md    [PIPE_LAT-1];

    always #5 clk = ~clk;

    fpaddsub_issue_arbiter #(
        .NREQ     (NREQ),
        .PIPE_LAT (PIPE_LAT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_a        (req_a),
        .req_b        (req_b),
        .req_op       (req_op),
        .dp_valid     (dp_valid),
        .dp_a         (dp_a),
        .dp_b         (dp_b),
        .dp_op        (dp_op),
        .dp_res_valid (dp_res_valid),
        .dp_res       (dp_res),
        .res_valid    (res_valid),
        .res_data     (res_data),
        .res_ready    (res_ready),
        .err          (err)
    );

    function automatic logic [31:0] fp_model(input logic [31:0] a, input logic [31:0] b, input logic op);
        case ({op, a, b})
            {1'b0, 32'h3F800000, 32'h40000000}: fp_model = 32'h40400000;
            {1'b1, 32'h40400000, 32'h3F800000}: fp_model = 32'h40000000;
            {1'b0, 32'h40800000, 32'h40800000}: fp_model = 32'h41000000;
            {1'b1, 32'h41000000, 32'h40000000}: fp_model = 32'h40C00000;
            default:                            fp_model = 32'hDEADBEEF;
        endcase
    endfunction

    // Behavioural datapath sharing the arbiter's reset.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < PIPE_LAT-1; i++) begin
                mv[i]    <= 1'b0;
                mdrop[i] <= 1'b0;
                md[i]    <= '0;
            end
        end else begin
            mv[0]    <= dp_valid;
            mdrop[0] <= drop_req2 && (dp_a == 32'h40800000);
            md[0]    <= fp_model(dp_a, dp_b, dp_op);
            for (int i = 1; i < PIPE_LAT-1; i++) begin
                mv[i]    <= mv[i-1];
                mdrop[i] <= mdrop[i-1];
                md[i]    <= md[i-1];
            end
        end
    end

    assign dp_res_valid = (mv[PIPE_LAT-2] & ~mdrop[PIPE_LAT-2]) | spur;
    assign dp_res       = md[PIPE_LAT-2];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req_valid = '0;
        res_ready = '0;
        spur      = 1'b0;
        drop_req2 = 1'b0;
        rst       = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        req_valid = 4'hF;
        step();
        checks++; if (req_ready !== 4'b0000) begin failures++; $display("[TB] FAIL reset_req_ready: got %b expected %b", req_ready, 4'b0000); end
        checks++; if (dp_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_dp_valid: got %b expected 0", dp_valid); end
        checks++; if (dp_a !== 32'h0) begin failures++; $display("[TB] FAIL reset_dp_a: got %h expected 0", dp_a); end
        checks++; if (res_valid !== 4'b0000) begin failures++; $display("[TB] FAIL reset_res_valid: got %b expected 0000", res_valid); end
        checks++; if (res_data !== '0) begin failures++; $display("[TB] FAIL reset_res_data: got %h expected 0", res_data); end
        checks++; if (err !== 1'b0) begin failures++; $display("[TB] FAIL reset_err: got %b expected 0", err); end
        req_valid = '0;
        rst = 1'b0;
    endtask

    task automatic test_single_op();
        do_reset();
        req_valid = 4'b0001;
        #1;
        checks++; if (req_ready !== 4'b0001) begin failures++; $display("[TB] FAIL single_grant: got %b expected 0001", req_ready); end
        step();
        req_valid = '0;
        #1;
        checks++; if (dp_valid !== 1'b1) begin failures++; $display("[TB] FAIL single_dp_valid: got %b expected 1", dp_valid); end
        checks++; if (dp_a !== 32'h3F800000 || dp_b !== 32'h40000000 || dp_op !== 1'b0)
            begin failures++; $display("[TB] FAIL single_dp_ops: got a=%h b=%h op=%b expected a=3f800000 b=40000000 op=0", dp_a, dp_b, dp_op); end
        repeat (3) step();
        checks++; if (res_valid !== 4'b0000) begin failures++; $display("[TB] FAIL single_early: got %b expected 0000 at cycle 4", res_valid); end
        step();
        checks++; if (res_valid !== 4'b0001) begin failures++; $display("[TB] FAIL single_res_valid: got %b expected 0001 at cycle 5", res_valid); end
        checks++; if (res_data[31:0] !== 32'h40400000) begin failures++; $display("[TB] FAIL single_res_data: got %h expected 40400000", res_data[31:0]); end
        checks++; if (err !== 1'b0) begin failures++; $display("[TB] FAIL single_err: got %b expected 0", err); end
        res_ready = 4'b0001;
        step();
        res_ready = '0;
        checks++; if (res_valid !== 4'b0000) begin failures++; $display("[TB] FAIL single_consume: got %b expected 0000", res_valid); end
    endtask

    task automatic test_back_to_back();
        logic [3:0] expg;
        do_reset();
        req_valid = 4'hF;
        for (int k = 0; k < 4; k++) begin
            expg = 4'(1 << k);
            #1;
            checks++; if (req_ready !== expg) begin failures++; $display("[TB] FAIL b2b_grant%0d: got %b expected %b", k, req_ready, expg); end
            step();
            checks++; if (dp_valid !== 1'b1 || dp_a !== A_OPS[k] || dp_b !== B_OPS[k])
                begin failures++; $display("[TB] FAIL b2b_issue%0d: got v=%b a=%h b=%h expected v=1 a=%h b=%h", k, dp_valid, dp_a, dp_b, A_OPS[k], B_OPS[k]); end
        end
        for (int c = 4; c < 9; c++) begin
            #1;
            checks++; if (req_ready !== 4'b0000) begin failures++; $display("[TB] FAIL b2b_busy_c%0d: got %b expected 0000", c, req_ready); end
            step();
        end
        checks++; if (res_valid !== 4'hF) begin failures++; $display("[TB] FAIL b2b_res_valid: got %b expected 1111", res_valid); end
        for (int k = 0; k < 4; k++) begin
            checks++; if (res_data[32*k +: 32] !== EXP[k]) begin failures++; $display("[TB] FAIL b2b_slot%0d: got %h expected %h", k, res_data[32*k +: 32], EXP[k]); end
        end
        req_valid = '0;
    endtask

    task automatic test_fairness();
        do_reset();
        req_valid = 4'b0010;
        #1;
        checks++; if (req_ready !== 4'b0010) begin failures++; $display("[TB] FAIL fair_first: got %b expected 0010", req_ready); end
        step();
        req_valid = 4'b1001;
        #1;
        checks++; if (req_ready !== 4'b1000) begin failures++; $display("[TB] FAIL fair_wrap3: got %b expected 1000", req_ready); end
        step();
        #1;
        checks++; if (req_ready !== 4'b0001) begin failures++; $display("[TB] FAIL fair_wrap0: got %b expected 0001", req_ready); end
        step();
        #1;
        checks++; if (req_ready !== 4'b0000) begin failures++; $display("[TB] FAIL fair_idle: got %b expected 0000", req_ready); end
        req_valid = '0;
        repeat (5) step();
        checks++; if (res_valid !== 4'b1011) begin failures++; $display("[TB] FAIL fair_slots: got %b expected 1011", res_valid); end
        res_ready = 4'hF;
        step();
        res_ready = '0;
        req_valid = 4'hF;
        #1;
        checks++; if (req_ready !== 4'b0010) begin failures++; $display("[TB] FAIL fair_ptr1: got %b expected 0010", req_ready); end
        step();
        req_valid = '0;
    endtask

    task automatic test_backpressure();
        do_reset();
        req_valid = 4'b0010;
        step();
        repeat (4) step();
        checks++; if (res_valid !== 4'b0010 || res_data[63:32] !== 32'h40000000)
            begin failures++; $display("[TB] FAIL bp_result: got v=%b d=%h expected v=0010 d=40000000", res_valid, res_data[63:32]); end
        for (int c = 0; c < 10; c++) begin
            #1;
            checks++; if (req_ready[1] !== 1'b0 || res_data[63:32] !== 32'h40000000)
                begin failures++; $display("[TB] FAIL bp_hold%0d: got rdy=%b d=%h expected rdy=0 d=40000000", c, req_ready[1], res_data[63:32]); end
            step();
        end
        res_ready = 4'b0010;
        #1;
        checks++; if (req_ready !== 4'b0000) begin failures++; $display("[TB] FAIL bp_same_cycle: got %b expected 0000", req_ready); end
        step();
        res_ready = '0;
        #1;
        checks++; if (res_valid !== 4'b0000) begin failures++; $display("[TB] FAIL bp_consumed: got %b expected 0000", res_valid); end
        checks++; if (req_ready !== 4'b0010) begin failures++; $display("[TB] FAIL bp_regrant: got %b expected 0010", req_ready); end
        step();
        req_valid = '0;
    endtask

    task automatic test_missing_result();
        do_reset();
        drop_req2 = 1'b1;
        req_valid = 4'b0100;
        #1;
        checks++; if (req_ready !== 4'b0100) begin failures++; $display("[TB] FAIL miss_grant: got %b expected 0100", req_ready); end
        step();
        req_valid = '0;
        repeat (3) step();
        checks++; if (err !== 1'b0) begin failures++; $display("[TB] FAIL miss_err_early: got %b expected 0", err); end
        step();
        drop_req2 = 1'b0;
        checks++; if (res_valid !== 4'b0100 || res_data[95:64] !== 32'h7FC00000)
            begin failures++; $display("[TB] FAIL miss_qnan: got v=%b d=%h expected v=0100 d=7fc00000", res_valid, res_data[95:64]); end
        checks++; if (err !== 1'b1) begin failures++; $display("[TB] FAIL miss_err: got %b expected 1", err); end
        spur = 1'b1;
        step();
        spur = 1'b0;
        checks++; if (err !== 1'b1 || res_valid !== 4'b0100 || res_data !== {32'h0, 32'h7FC00000, 64'h0})
            begin failures++; $display("[TB] FAIL spur_slots: got err=%b v=%b d=%h expected err=1 v=0100 d=%h", err, res_valid, res_data, {32'h0, 32'h7FC00000, 64'h0}); end
        do_reset();
        checks++; if (err !== 1'b0) begin failures++; $display("[TB] FAIL spur_pre: got %b expected 0", err); end
        spur = 1'b1;
        step();
        spur = 1'b0;
        checks++; if (err !== 1'b1 || res_valid !== 4'b0000)
            begin failures++; $display("[TB] FAIL spur_fresh: got err=%b v=%b expected err=1 v=0000", err, res_valid); end
    endtask

    task automatic test_async_reset();
        do_reset();
        req_valid = 4'b0111;
        repeat (3) step();
        checks++; if (dp_valid !== 1'b1 || dp_a !== 32'h40800000)
            begin failures++; $display("[TB] FAIL arst_pre: got v=%b a=%h expected v=1 a=40800000", dp_valid, dp_a); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (dp_valid !== 1'b0 || dp_a !== 32'h0 || req_ready !== 4'b0000 || res_valid !== 4'b0000 || err !== 1'b0)
            begin failures++; $display("[TB] FAIL arst_now: got v=%b a=%h rdy=%b rv=%b err=%b expected all 0", dp_valid, dp_a, req_ready, res_valid, err); end
        step();
        req_valid = '0;
        rst = 1'b0;
        for (int c = 0; c < 8; c++) begin
            step();
            checks++; if (res_valid !== 4'b0000 || err !== 1'b0)
                begin failures++; $display("[TB] FAIL arst_quiet%0d: got v=%b err=%b expected v=0000 err=0", c, res_valid, err); end
        end
        req_valid = 4'b0001;
        #1;
        checks++; if (req_ready !== 4'b0001) begin failures++; $display("[TB] FAIL arst_ptr0: got %b expected 0001", req_ready); end
        step();
        req_valid = '0;
        repeat (4) step();
        checks++; if (res_valid !== 4'b0001 || res_data[31:0] !== 32'h40400000)
            begin failures++; $display("[TB] FAIL arst_reissue: got v=%b d=%h expected v=0001 d=40400000", res_valid, res_data[31:0]); end
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        res_ready = '0;
        spur      = 1'b0;
        drop_req2 = 1'b0;
        req_op    = 4'b1010;
        for (int k = 0; k < 4; k++) begin
            req_a[32*k +: 32] = A_OPS[k];
            req_b[32*k +: 32] = B_OPS[k];
        end
        test_reset();
        test_single_op();
        test_back_to_back();
        test_fairness();
        test_backpressure();
        test_missing_result();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
